// File: rtl/dso_spi_pkg.sv
// Shared definitions for the DSO SPI link: frame width, slave FSM encoding and
// the slave-select codes also used by the top-level SS decode.
package dso_spi_pkg;

  localparam int SPI_WIDTH = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_slv_state_e;

  typedef enum logic [2:0] {
    TRIG = 3'd0,
    CH1  = 3'd1,
    CH2  = 3'd2,
    CH3  = 3'd3,
    EEP  = 3'd4
  } spi_ss_sel_e;

endpackage

// File: rtl/spi_slv_sync.sv
// Synchroniser for one asynchronous SPI pin: STAGES-deep flop chain plus one
// history flop, giving the synchronised level and 1-clk rise/fall pulses.
module spi_slv_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Metastability chain and edge-history flop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = sync_q[STAGES-1] & ~prev_q;
  assign fall_o  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_slv_resp.sv
// SPI mode-0 responder: receives one WIDTH-bit command per SS_n frame and returns a
// preloaded response on MISO. Optional frm_err output under SPI_SLV_FRAME_ERR_EN.
module spi_slv_resp
  import dso_spi_pkg::*;
#(
  parameter int WIDTH       = SPI_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             SS_n,
  input  logic             SCLK,
  input  logic             MOSI,
  output logic             MISO,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             wrt,
  output logic             rsp_rdy,
  output logic [WIDTH-1:0] cmd_rcvd,
  output logic             cmd_rdy,
  input  logic             clr_cmd_rdy
`ifdef SPI_SLV_FRAME_ERR_EN
  ,
  output logic             frm_err
`endif
);

  localparam int              CNT_W    = $clog2(WIDTH + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(WIDTH + 1);

  spi_slv_state_e   state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] shft_rx_q, shft_rx_d;
  logic [WIDTH-1:0] shft_tx_q, shft_tx_d;
  logic [WIDTH-1:0] rsp_buf_q, rsp_buf_d;
  logic [WIDTH-1:0] cmd_rcvd_q, cmd_rcvd_d;
  logic             rsp_rdy_q, rsp_rdy_d;
  logic             cmd_rdy_q, cmd_rdy_d;

  logic ss_lvl, ss_rise, ss_fall;
  logic sclk_lvl, sclk_rise, sclk_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;
  logic unused_sync_s;

  spi_slv_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
    .clk(clk), .rst_n(rst_n), .d_i(SS_n),
    .level_o(ss_lvl), .rise_o(ss_rise), .fall_o(ss_fall)
  );
  spi_slv_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .d_i(SCLK),
    .level_o(sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );
  spi_slv_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .d_i(MOSI),
    .level_o(mosi_lvl), .rise_o(mosi_rise), .fall_o(mosi_fall)
  );

  // Synchroniser outputs this block has no use for
  assign unused_sync_s = ^{ss_lvl, sclk_lvl, mosi_rise, mosi_fall};

  // Frame FSM, shifters, command capture and response buffer next state
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shft_rx_d  = shft_rx_q;
    shft_tx_d  = shft_tx_q;
    rsp_buf_d  = rsp_buf_q;
    rsp_rdy_d  = rsp_rdy_q;
    cmd_rcvd_d = cmd_rcvd_q;
    cmd_rdy_d  = cmd_rdy_q;

    if (clr_cmd_rdy) begin
      cmd_rdy_d = 1'b0;
    end else begin
      cmd_rdy_d = cmd_rdy_q;
    end

    case (state_q)
      IDLE: begin
        if (ss_fall) begin
          state_d   = SHIFT;
          shft_tx_d = rsp_buf_q;
          bit_cnt_d = '0;
          rsp_rdy_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (sclk_rise) begin
          shft_rx_d = {shft_rx_q[WIDTH-2:0], mosi_lvl};
          bit_cnt_d = (bit_cnt_q == CNT_SAT) ? bit_cnt_q : bit_cnt_q + CNT_W'(1);
        end else begin
          shft_rx_d = shft_rx_q;
        end
        // MSB is already on MISO at frame start, so the first fall before any rise must not shift
        if (sclk_fall && (bit_cnt_q != '0)) begin
          shft_tx_d = {shft_tx_q[WIDTH-2:0], 1'b0};
        end else begin
          shft_tx_d = shft_tx_q;
        end
        if (ss_rise) begin
          state_d = IDLE;
          if (bit_cnt_d == CNT_FULL) begin
            cmd_rcvd_d = shft_rx_d;
            cmd_rdy_d  = 1'b1;
          end else begin
            cmd_rcvd_d = cmd_rcvd_q;
          end
        end else begin
          state_d = SHIFT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A write always wins the ready flag, even on the clk a frame starts
    if (wrt) begin
      rsp_buf_d = tx_data;
      rsp_rdy_d = 1'b1;
    end else begin
      rsp_buf_d = rsp_buf_q;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shft_rx_q  <= '0;
      shft_tx_q  <= '0;
      rsp_buf_q  <= '0;
      rsp_rdy_q  <= 1'b0;
      cmd_rcvd_q <= '0;
      cmd_rdy_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shft_rx_q  <= shft_rx_d;
      shft_tx_q  <= shft_tx_d;
      rsp_buf_q  <= rsp_buf_d;
      rsp_rdy_q  <= rsp_rdy_d;
      cmd_rcvd_q <= cmd_rcvd_d;
      cmd_rdy_q  <= cmd_rdy_d;
    end
  end

`ifdef SPI_SLV_FRAME_ERR_EN
  logic frm_err_q, frm_err_d;

  // Flag any frame that ends with other than exactly WIDTH bits
  always_comb begin
    frm_err_d = (state_q == SHIFT) && ss_rise && (bit_cnt_d != CNT_FULL);
  end

  // Frame-error pulse register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frm_err_q <= 1'b0;
    end else begin
      frm_err_q <= frm_err_d;
    end
  end

  assign frm_err = frm_err_q;
`endif

  assign MISO     = SS_n ? 1'bz : shft_tx_q[WIDTH-1];
  assign rsp_rdy  = rsp_rdy_q;
  assign cmd_rcvd = cmd_rcvd_q;
  assign cmd_rdy  = cmd_rdy_q;

endmodule

// File: tb/tb_spi_slv_resp.sv
// Directed bench for spi_slv_resp: acts as an SPI mode-0 master at clk/16 and
// checks commands, responses and flags against hand-computed values.
module tb_spi_slv_resp;
  import dso_spi_pkg::*;

  localparam int W    = SPI_WIDTH;
  localparam int SYNC = 2;
  localparam int HALF = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         SS_n = 1'b1;
  logic         SCLK = 1'b0;
  logic         MOSI = 1'b0;
  logic         MISO;
  logic [W-1:0] tx_data = '0;
  logic         wrt = 1'b0;
  logic         rsp_rdy;
  logic [W-1:0] cmd_rcvd;
  logic         cmd_rdy;
  logic         clr_cmd_rdy = 1'b0;
  logic [W-1:0] rsp;
  int           checks = 0;
  int           errors = 0;

`ifdef SPI_SLV_FRAME_ERR_EN
  logic frm_err;
  int   frm_pulses = 0;
  always @(negedge clk) if (frm_err === 1'b1) frm_pulses++;
`endif

  always #5 clk = ~clk;

  spi_slv_resp #(.WIDTH(W), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
    .tx_data(tx_data), .wrt(wrt), .rsp_rdy(rsp_rdy), .cmd_rcvd(cmd_rcvd),
    .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy)
`ifdef SPI_SLV_FRAME_ERR_EN
    , .frm_err(frm_err)
`endif
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pulse_wrt(input logic [W-1:0] data);
    tx_data = data;
    wrt = 1'b1;
    tick(1);
    wrt = 1'b0;
  endtask

  // One SCLK period: MISO sampled just before the rising edge, like the master
  task automatic spi_bit(input logic b);
    MOSI = b;
    tick(HALF);
    rsp = {rsp[W-2:0], MISO};
    SCLK = 1'b1;
    tick(HALF);
    SCLK = 1'b0;
  endtask

  task automatic spi_start();
    SS_n = 1'b0;
    rsp = '0;
    tick(HALF);
  endtask

  task automatic spi_bits(input logic [W-1:0] cmd, input int n);
    for (int i = 0; i < n; i++) spi_bit(cmd[W-1-i]);
  endtask

  task automatic spi_end();
    tick(HALF);
    SS_n = 1'b1;
    tick(HALF);
  endtask

  task automatic spi_frame(input logic [W-1:0] cmd);
    spi_start();
    spi_bits(cmd, W);
    spi_end();
  endtask

  initial begin
    tick(3);
    check("reset_cmd_rcvd", cmd_rcvd, 16'h0000);
    check("reset_cmd_rdy", {15'd0, cmd_rdy}, 16'h0000);
    check("reset_rsp_rdy", {15'd0, rsp_rdy}, 16'h0000);
    rst_n = 1'b1;
    tick(2);

    // 1 basic frame
    pulse_wrt(16'h0001);
    check("t1_rsp_rdy_loaded", {15'd0, rsp_rdy}, 16'h0001);
    spi_start();
    check("t1_rsp_rdy_taken", {15'd0, rsp_rdy}, 16'h0000);
    spi_bits(16'hA5C3, W);
    spi_end();
    check("t1_cmd_rcvd", cmd_rcvd, 16'hA5C3);
    check("t1_cmd_rdy", {15'd0, cmd_rdy}, 16'h0001);
    check("t1_response", rsp, 16'h0001);

    // 2 back-to-back without clearing
    spi_frame(16'h1234);
    check("t2_cmd_rcvd_a", cmd_rcvd, 16'h1234);
    check("t2_response_a", rsp, 16'h0001);
    spi_frame(16'hFFFF);
    check("t2_cmd_rcvd_b", cmd_rcvd, 16'hFFFF);
    check("t2_cmd_rdy", {15'd0, cmd_rdy}, 16'h0001);
    check("t2_response_b", rsp, 16'h0001);

    // 3 short frame of 8 bits
`ifdef SPI_SLV_FRAME_ERR_EN
    frm_pulses = 0;
`endif
    spi_start();
    spi_bits(16'h5A00, 8);
    spi_end();
    check("t3_cmd_rcvd", cmd_rcvd, 16'hFFFF);
    check("t3_cmd_rdy", {15'd0, cmd_rdy}, 16'h0001);
`ifdef SPI_SLV_FRAME_ERR_EN
    check("t3_frm_err_pulses", W'(frm_pulses), 16'h0001);
`endif

    // 4 clear coinciding with frame completion
    clr_cmd_rdy = 1'b1;
    tick(1);
    clr_cmd_rdy = 1'b0;
    check("t4_cleared", {15'd0, cmd_rdy}, 16'h0000);
    spi_start();
    spi_bits(16'h00FF, W);
    tick(HALF);
    SS_n = 1'b1;
    tick(SYNC);
    clr_cmd_rdy = 1'b1;
    tick(1);
    clr_cmd_rdy = 1'b0;
    tick(HALF);
    check("t4_cmd_rdy", {15'd0, cmd_rdy}, 16'h0001);
    check("t4_cmd_rcvd", cmd_rcvd, 16'h00FF);

    // 5 reset mid-frame, with a pending write that the reset must discard
    spi_start();
    spi_bits(16'hDEAD, 7);
    pulse_wrt(16'h7777);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    check("t5_cmd_rcvd_reset", cmd_rcvd, 16'h0000);
    check("t5_cmd_rdy_reset", {15'd0, cmd_rdy}, 16'h0000);
    check("t5_rsp_rdy_reset", {15'd0, rsp_rdy}, 16'h0000);
    spi_bits(16'hDEAD << 7, 9);
    spi_end();
    check("t5_tail_ignored", {15'd0, cmd_rdy}, 16'h0000);
    spi_frame(16'h0F0F);
    check("t5_cmd_rcvd", cmd_rcvd, 16'h0F0F);
    check("t5_cmd_rdy", {15'd0, cmd_rdy}, 16'h0001);
    check("t5_response", rsp, 16'h0000);

    // 6 write during the 5th bit affects only the next frame
    pulse_wrt(16'h1357);
    spi_start();
    for (int i = 0; i < W; i++) begin
      if (i == 4) pulse_wrt(16'hBEEF);
      spi_bit(i[0]);
    end
    spi_end();
    check("t6_response_old", rsp, 16'h1357);
    check("t6_rsp_rdy_between", {15'd0, rsp_rdy}, 16'h0001);
    check("t6_cmd_rcvd", cmd_rcvd, 16'h5555);
    spi_frame(16'h3C3C);
    check("t6_response_new", rsp, 16'hBEEF);
    check("t6_rsp_rdy_after", {15'd0, rsp_rdy}, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
